// File: rtl/uart_tx_if.sv
// AXI-stream byte channel feeding the UART transmitter.
// The producer drives tdata/tvalid and the transmitter answers with tready.
interface uart_tx_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: an AXI-stream byte is taken into a one-entry holding
// register and shifted out LSB-first on tx, back-to-back when the next byte is already held.
module uart_tx #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD      = 115200,
  parameter int STOP_BITS = 1
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave s_axis_din,
  output logic     tx,
  output logic     busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_rate
      $error("uart_tx: CLK_FREQ/BAUD must be at least 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
      $error("uart_tx: STOP_BITS must be 1 or 2");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_valid_q, hold_valid_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             tready_s;
  logic             handshake_s;
  logic             last_tick_s;
  logic             load_s;

  // Next-state logic for the frame sequencer, holding register and registered line outputs.
  always_comb begin
    tready_s    = !hold_valid_q && !rst;
    handshake_s = s_axis_din.tvalid && tready_s;
    last_tick_s = (cnt_q == CNT_LAST);
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    load_s      = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = {CNT_W{1'b0}};
        bit_d = 3'd0;
        if (hold_valid_q) begin
          load_s  = 1'b1;
          shift_d = hold_q;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (last_tick_s) begin
          cnt_d   = {CNT_W{1'b0}};
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (last_tick_s) begin
          cnt_d   = {CNT_W{1'b0}};
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (last_tick_s) begin
          cnt_d = {CNT_W{1'b0}};
          if (bit_q == STOP_LAST) begin
            bit_d = 3'd0;
            // A held byte goes straight into its start bit with no idle cycle.
            if (hold_valid_q) begin
              load_s  = 1'b1;
              shift_d = hold_q;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = {CNT_W{1'b0}};
        bit_d   = 3'd0;
      end
    endcase

    // Capture and consume can never coincide: capture needs the hold empty, consume needs it full.
    hold_d       = handshake_s ? s_axis_din.tdata : hold_q;
    hold_valid_d = hold_valid_q ? !load_s : handshake_s;

    case (state_d)
      S_IDLE:  tx_d = 1'b1;
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      S_STOP:  tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE) || hold_valid_d;
  end

  // State registers with synchronous reset; reset drops any frame in flight and the held byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      bit_q        <= 3'd0;
      shift_q      <= 8'd0;
      hold_q       <= 8'd0;
      hold_valid_q <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
    end
  end

  assign s_axis_din.tready = tready_s;
  assign tx                = tx_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (16 clk/bit with 1 and 2 stop bits, default rate)
// checked against an expected line waveform built from the 8N1 framing rules.
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_v;
  logic [2:0] tvalid_v;
  logic [7:0] tdata_v [3];
  wire  [2:0] tready_w;
  wire  [2:0] tx_w;
  wire  [2:0] busy_w;

  int checks   = 0;
  int failures = 0;

  uart_tx_if if_a ();
  uart_tx_if if_b ();
  uart_tx_if if_c ();

  assign if_a.tdata  = tdata_v[0];
  assign if_a.tvalid = tvalid_v[0];
  assign tready_w[0] = if_a.tready;
  assign if_b.tdata  = tdata_v[1];
  assign if_b.tvalid = tvalid_v[1];
  assign tready_w[1] = if_b.tready;
  assign if_c.tdata  = tdata_v[2];
  assign if_c.tvalid = tvalid_v[2];
  assign tready_w[2] = if_c.tready;

  uart_tx #(.CLK_FREQ(16), .BAUD(1), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst_v[0]), .s_axis_din(if_a), .tx(tx_w[0]), .busy(busy_w[0]));
  uart_tx #(.CLK_FREQ(16), .BAUD(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst_v[1]), .s_axis_din(if_b), .tx(tx_w[1]), .busy(busy_w[1]));
  uart_tx #(.CLK_FREQ(100000000), .BAUD(115200), .STOP_BITS(1)) dut_c (
    .clk(clk), .rst(rst_v[2]), .s_axis_din(if_c), .tx(tx_w[2]), .busy(busy_w[2]));

  logic [7:0] stim [$];
  logic       exp_tx [$];
  logic       exp_busy [$];
  logic       exp_rdy [$];
  logic       obs_tx [$];
  logic       obs_busy [$];
  logic       obs_rdy [$];
  int         hs [$];

  function automatic int cpb(input int d);
    return (d == 2) ? 868 : 16;
  endfunction

  function automatic int stopb(input int d);
    return (d == 1) ? 2 : 1;
  endfunction

  function automatic int flen(input int d);
    return (9 + stopb(d)) * cpb(d);
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  // Streams every byte of stim into DUT d with tvalid held high, records the line,
  // then compares against frames built bit by bit from the bytes.
  task automatic run_stream(input int d, input string tag, input int tail);
    int n, f, idx, total, hk, sk, obs_h, d_tx, d_busy, d_rdy;
    logic fire;
    n = stim.size();
    f = flen(d);
    exp_tx.delete(); exp_busy.delete(); exp_rdy.delete();
    obs_tx.delete(); obs_busy.delete(); obs_rdy.delete(); hs.delete();
    exp_tx.push_back(1'b1); exp_tx.push_back(1'b1);
    exp_busy.push_back(1'b0); exp_busy.push_back(1'b1);
    for (int k = 0; k < n; k++) begin
      for (int r = 0; r < cpb(d); r++) exp_tx.push_back(1'b0);
      for (int i = 0; i < 8; i++)
        for (int r = 0; r < cpb(d); r++) exp_tx.push_back(stim[k][i]);
      for (int r = 0; r < stopb(d) * cpb(d); r++) exp_tx.push_back(1'b1);
      for (int r = 0; r < f; r++) exp_busy.push_back(1'b1);
    end
    for (int r = 0; r < tail; r++) begin
      exp_tx.push_back(1'b1);
      exp_busy.push_back(1'b0);
    end
    total = exp_tx.size();
    for (int c = 0; c < total; c++) exp_rdy.push_back(1'b1);
    // Hold is full from each acceptance until its frame is loaded.
    for (int k = 0; k < n; k++) begin
      hk = (k == 0) ? 0 : 2 + (k - 1) * f;
      sk = 1 + k * f;
      for (int c = hk + 1; c <= sk; c++) exp_rdy[c] = 1'b0;
    end

    idx = 0;
    tvalid_v[d] = 1'b1;
    tdata_v[d]  = stim[0];
    for (int c = 0; c < total; c++) begin
      obs_tx.push_back(tx_w[d]);
      obs_busy.push_back(busy_w[d]);
      obs_rdy.push_back(tready_w[d]);
      fire = tvalid_v[d] && tready_w[d];
      if (fire) hs.push_back(c);
      @(negedge clk);
      if (fire) begin
        idx++;
        if (idx < n) tdata_v[d] = stim[idx];
        else tvalid_v[d] = 1'b0;
      end
    end
    tvalid_v[d] = 1'b0;

    check({tag, " accepted"}, idx, n);
    for (int k = 0; k < n; k++) begin
      obs_h = (k < hs.size()) ? hs[k] : -1;
      check({tag, " handshake_cycle"}, obs_h, (k == 0) ? 0 : 2 + (k - 1) * f);
    end
    d_tx = -1; d_busy = -1; d_rdy = -1;
    for (int i = 0; i < total; i++) begin
      if (d_tx < 0 && obs_tx[i] !== exp_tx[i]) d_tx = i;
      if (d_busy < 0 && obs_busy[i] !== exp_busy[i]) d_busy = i;
      if (d_rdy < 0 && obs_rdy[i] !== exp_rdy[i]) d_rdy = i;
    end
    check({tag, " tx_first_diff"}, d_tx, -1);
    check({tag, " busy_first_diff"}, d_busy, -1);
    check({tag, " tready_first_diff"}, d_rdy, -1);
  endtask

  logic [7:0] x_b, y_b;
  int bad;

  initial begin
    rst_v    = 3'b111;
    tvalid_v = 3'b000;
    for (int d = 0; d < 3; d++) tdata_v[d] = 8'h00;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("reset tx", tx_w[d], 1);
      check("reset busy", busy_w[d], 0);
      check("reset tready", tready_w[d], 0);
    end
    rst_v = 3'b000;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("post_reset tx", tx_w[d], 1);
      check("post_reset busy", busy_w[d], 0);
      check("post_reset tready", tready_w[d], 1);
    end

    stim = '{8'hA5};
    run_stream(0, "basic_a5", 8);
    check("basic_a5 busy_cycles", obs_busy.sum() with (int'(item)), 161);

    stim = '{8'h00, 8'hFF};
    run_stream(0, "b2b", 8);
    check("b2b stop_end", obs_tx[2 + 159], 1);
    check("b2b second_start", obs_tx[2 + 160], 0);

    stim = '{8'h01, 8'h02, 8'h03};
    run_stream(0, "backpressure", 8);

    stim.delete();
    for (int k = 0; k < 4; k++) stim.push_back(8'($urandom_range(0, 255)));
    run_stream(0, "random4", 8);

    stim = '{8'h3C, 8'($urandom_range(0, 255))};
    run_stream(1, "stop2", 8);
    check("stop2 stop_last_high", obs_tx[2 + 175], 1);
    check("stop2 next_start_176", obs_tx[2 + 176], 0);

    stim = '{8'h55};
    run_stream(2, "default_rate", 4);
    check("default start_last", obs_tx[2 + 867], 0);
    check("default bit0_at_868", obs_tx[2 + 868], 1);
    check("default frame_end_8680", obs_tx[2 + 8680], 1);

    // Reset in the middle of data bit 4 while a second byte is held.
    x_b = 8'($urandom_range(0, 255));
    y_b = 8'($urandom_range(0, 255));
    tvalid_v[0] = 1'b1;
    tdata_v[0]  = x_b;
    @(negedge clk);
    check("rst tready_after_accept", tready_w[0], 0);
    tdata_v[0] = y_b;
    @(negedge clk);
    check("rst tready_after_load", tready_w[0], 1);
    @(negedge clk);
    tvalid_v[0] = 1'b0;
    check("rst held busy", busy_w[0], 1);
    check("rst held tready", tready_w[0], 0);
    repeat (88) @(negedge clk);
    check("rst data_bit4", tx_w[0], x_b[4]);
    rst_v[0] = 1'b1;
    #1;
    check("rst tready_during", tready_w[0], 0);
    @(negedge clk);
    check("rst tx_at_reset", tx_w[0], 1);
    check("rst busy_at_reset", busy_w[0], 0);
    check("rst tready_at_reset", tready_w[0], 0);
    rst_v[0] = 1'b0;
    #1;
    check("rst tready_release", tready_w[0], 1);
    bad = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) bad++;
    end
    check("rst no_resume", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
